// File: rtl/spi_eeprom_slave.sv
// spi_eeprom_slave: SPI mode-0 responder emulating a small 25xx-style EEPROM.
// Decodes WREN/WRDI/RDSR/WRSR/READ/WRITE, holds a DEPTH-byte array, models
// the write-in-progress busy period and upper-region block protection.
//
// Ports:
//   clk      system clock (>= 8x sck)
//   rst      asynchronous active-low reset
//   sck      SPI clock, idle low; mosi sampled on rise, miso updated on fall
//   csn      chip select, active low
//   mosi     serial data in, MSB first
//   miso     serial data out, MSB first
//   miso_oe  high while a response byte is being shifted
//   wip_o    status bit 0, write in progress
//   wel_o    status bit 1, write-enable latch
//   bp_o     status bits [3:2], block protect
//   cmd_err  one-clk pulse on rejected or illegal command
//
// Optional feature macro: SPI_EEPROM_SEQ_READ_EN
//   defined   - READ streams successive bytes, address wraps DEPTH-1 -> 0
//   undefined - READ returns one byte, then miso=0, miso_oe=0, state IGN
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | csn high, nothing framed
// CMD   | shifting the 8-bit opcode
// ADDR  | shifting the 8-bit address
// DIN   | shifting write data (bits past the first byte ignored)
// DOUT  | shifting array data out
// SOUT  | shifting status out, re-captured every byte
// SRIN  | shifting new status value in
// IGN   | ignore everything until csn rise

module spi_eeprom_slave #(
  parameter int DEPTH        = 128,
  parameter int ADDR_W       = 7,
  parameter int WRITE_CYCLES = 1000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       wip_o,
  output logic       wel_o,
  output logic [1:0] bp_o,
  output logic       cmd_err
);

  localparam int CNT_W = $clog2(WRITE_CYCLES + 1);

  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam logic [ADDR_W-1:0] Q3_BASE   = ADDR_W'(3 * DEPTH / 4);
  localparam logic [ADDR_W-1:0] HALF_BASE = ADDR_W'(DEPTH / 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DIN, S_DOUT, S_SOUT, S_SRIN, S_IGN
  } state_t;

  // Input synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic sck_q, csn_q;
  logic sck_s, csn_s, mosi_s;
  logic sck_rise, sck_fall, csn_rise, csn_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync  <= '0;
      csn_sync  <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], csn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_q     <= sck_sync[SYNC_STAGES-1];
      csn_q     <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign csn_rise = csn_s & ~csn_q;
  assign csn_fall = ~csn_s & csn_q;

  // Datapath registers
  state_t            state;
  logic [4:0]        bit_cnt;   // bits in this frame, saturates at 31
  logic [2:0]        out_cnt;   // bit position within the outgoing byte
  logic [6:0]        shift_in;
  logic [7:0]        op;        // 0x00 marks a rejected/illegal frame
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic [6:0]        dout;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [CNT_W-1:0]  busy_cnt;
`ifndef SPI_EEPROM_SEQ_READ_EN
  logic              first;
`endif

  logic [7:0] mem [DEPTH];
  logic [7:0] new_byte;
  logic [7:0] status;
  logic [7:0] rd_byte;
  logic       mem_we;

  assign new_byte = {shift_in, mosi_s};
  assign status   = {4'b0000, bp_o, wel_o, wip_o};
  assign rd_byte  = mem[addr];
  assign mem_we   = wip_o && (busy_cnt == CNT_W'(1));

  function automatic logic is_protected(input logic [ADDR_W-1:0] a,
                                        input logic [1:0] bp);
    case (bp)
      2'd1:    return a >= Q3_BASE;
      2'd2:    return a >= HALF_BASE;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Array is not reset; wip_o is, so a reset mid-busy never commits the byte.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      out_cnt  <= '0;
      shift_in <= '0;
      op       <= '0;
      addr     <= '0;
      din      <= '0;
      dout     <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy_cnt <= '0;
      miso     <= 1'b0;
      miso_oe  <= 1'b0;
      wip_o    <= 1'b0;
      wel_o    <= 1'b0;
      bp_o     <= 2'b00;
      cmd_err  <= 1'b0;
`ifndef SPI_EEPROM_SEQ_READ_EN
      first    <= 1'b0;
`endif
    end else begin
      cmd_err <= 1'b0;

      // Busy down-counter; completion clears WIP and WEL together.
      if (mem_we) begin
        wip_o    <= 1'b0;
        wel_o    <= 1'b0;
        busy_cnt <= '0;
      end else if (wip_o) begin
        busy_cnt <= busy_cnt - 1'b1;
      end

      if (csn_rise) begin
        state   <= S_IDLE;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        // Commands take effect at frame end only with the exact bit count.
        case (op)
          OP_WREN: if (bit_cnt == 5'd8) wel_o <= 1'b1;
          OP_WRDI: if (bit_cnt == 5'd8) wel_o <= 1'b0;
          OP_WRSR: if (bit_cnt == 5'd16) begin
            if (wel_o) begin
              bp_o  <= din[3:2];
              wel_o <= 1'b0;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          OP_WRITE: if (bit_cnt == 5'd24) begin
            if (wel_o && !is_protected(addr, bp_o)) begin
              wr_addr  <= addr;
              wr_data  <= din;
              wip_o    <= 1'b1;
              busy_cnt <= CNT_W'(WRITE_CYCLES);
            end else begin
              wel_o   <= 1'b0;
              cmd_err <= 1'b1;
            end
          end
          default: ;
        endcase
        op <= 8'h00;
      end else if (csn_fall) begin
        state   <= S_CMD;
        bit_cnt <= '0;
        out_cnt <= '0;
        op      <= 8'h00;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else if (state != S_IDLE && sck_rise) begin
        shift_in <= new_byte[6:0];
        if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
        case (state)
          S_CMD: if (bit_cnt == 5'd7) begin
            out_cnt <= '0;
            if (wip_o && new_byte != OP_RDSR) begin
              state   <= S_IGN;
              cmd_err <= 1'b1;
            end else begin
              case (new_byte)
                OP_WREN, OP_WRDI: begin op <= new_byte; state <= S_IGN;  end
                OP_RDSR:          begin op <= new_byte; state <= S_SOUT; end
                OP_WRSR:          begin op <= new_byte; state <= S_SRIN; end
                OP_READ, OP_WRITE: begin op <= new_byte; state <= S_ADDR; end
                default: begin
                  state   <= S_IGN;
                  cmd_err <= 1'b1;
                end
              endcase
            end
          end
          S_ADDR: if (bit_cnt == 5'd15) begin
            addr  <= new_byte[ADDR_W-1:0];
            state <= (op == OP_READ) ? S_DOUT : S_DIN;
`ifndef SPI_EEPROM_SEQ_READ_EN
            first <= 1'b1;
`endif
          end
          S_DIN:  if (bit_cnt == 5'd23) din <= new_byte;
          S_SRIN: if (bit_cnt == 5'd15) din <= new_byte;
          default: ;
        endcase
      end else if (state != S_IDLE && sck_fall) begin
        case (state)
          S_SOUT: begin
            // Status is snapshotted at each byte start so polling sees WIP fall.
            if (out_cnt == 3'd0) begin
              miso <= status[7];
              dout <= status[6:0];
            end else begin
              miso <= dout[6];
              dout <= {dout[5:0], 1'b0};
            end
            miso_oe <= 1'b1;
            out_cnt <= out_cnt + 3'd1;
          end
          S_DOUT: begin
`ifdef SPI_EEPROM_SEQ_READ_EN
            if (out_cnt == 3'd0) begin
              miso <= rd_byte[7];
              dout <= rd_byte[6:0];
            end else begin
              miso <= dout[6];
              dout <= {dout[5:0], 1'b0};
            end
            if (out_cnt == 3'd7) addr <= addr + 1'b1;
            miso_oe <= 1'b1;
            out_cnt <= out_cnt + 3'd1;
`else
            if (out_cnt == 3'd0) begin
              if (first) begin
                miso    <= rd_byte[7];
                dout    <= rd_byte[6:0];
                miso_oe <= 1'b1;
                first   <= 1'b0;
              end else begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
                state   <= S_IGN;
              end
            end else begin
              miso <= dout[6];
              dout <= {dout[5:0], 1'b0};
            end
            out_cnt <= out_cnt + 3'd1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Directed bench for spi_eeprom_slave: acts as a mode-0 SPI master, runs the
// write/poll/read, unprotected/protected, aborted-frame, sequential-read and
// reset-during-busy scenarios, and checks against hand-computed values.
module tb_spi_eeprom_slave;

  localparam int WC   = 200;
  localparam int HALF = 50;   // sck half period, 10 clk per sck period

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       csn = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wip_o, wel_o, cmd_err;
  logic [1:0] bp_o;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;

  spi_eeprom_slave #(
    .DEPTH(128), .ADDR_W(7), .WRITE_CYCLES(WC), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst), .sck(sck), .csn(csn), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .wip_o(wip_o), .wel_o(wel_o),
    .bp_o(bp_o), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && cmd_err) err_pulses <= err_pulses + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      #HALF;
      sck = 1'b1;
      rx[i] = miso;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    csn = 1'b0;
    #100;
  endtask

  task automatic cs_end();
    #20;
    csn = 1'b1;
    mosi = 1'b0;
    #100;
  endtask

  task automatic frame1(input logic [7:0] opc);
    logic [7:0] r;
    cs_start();
    xfer(opc, 8, r);
    cs_end();
  endtask

  task automatic do_write_raw(input logic [7:0] a, input logic [7:0] d);
    logic [7:0] r;
    cs_start();
    xfer(8'h02, 8, r);
    xfer(a, 8, r);
    xfer(d, 8, r);
    cs_end();
  endtask

  task automatic do_read(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] r;
    cs_start();
    xfer(8'h03, 8, r);
    xfer(a, 8, r);
    xfer(8'h00, 8, d);
    cs_end();
  endtask

  task automatic read_status(output logic [7:0] s);
    logic [7:0] r;
    cs_start();
    xfer(8'h05, 8, r);
    xfer(8'h00, 8, s);
    cs_end();
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (wip_o === 1'b1 && n < WC + 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (wip_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: wip got %b want 0", name, wip_o);
    end
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [7:0] d);
    frame1(8'h06);
    do_write_raw(a, d);
    wait_idle("write_mem");
  endtask

  task automatic test_reset();
    logic [7:0] s;
    total++;
    if ({miso, miso_oe, wip_o, wel_o, bp_o, cmd_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outs: got %b want 0000000",
               {miso, miso_oe, wip_o, wel_o, bp_o, cmd_err});
    end
    read_status(s);
    total++;
    if (s !== 8'h00) begin bad++; $display("FAIL reset_rdsr: got %h want 00", s); end
  endtask

  task automatic test_write_poll_read();
    logic [7:0] r, s, s0;
    int n;
    frame1(8'h06);
    total++;
    if (wel_o !== 1'b1) begin bad++; $display("FAIL wren_wel: got %b want 1", wel_o); end
    do_write_raw(8'h05, 8'hA5);
    total++;
    if (wip_o !== 1'b1) begin bad++; $display("FAIL write_wip: got %b want 1", wip_o); end
    cs_start();
    xfer(8'h05, 8, r);
    xfer(8'h00, 8, s0);
    s = s0;
    n = 0;
    while (s !== 8'h00 && n < 40) begin
      xfer(8'h00, 8, s);
      n++;
    end
    #20;
    total++;
    if (s0 !== 8'h03) begin bad++; $display("FAIL poll_busy: got %h want 03", s0); end
    total++;
    if (s !== 8'h00) begin bad++; $display("FAIL poll_done: got %h want 00", s); end
    total++;
    if (miso_oe !== 1'b1) begin bad++; $display("FAIL rdsr_oe: got %b want 1", miso_oe); end
    cs_end();
    total++;
    if (miso_oe !== 1'b0) begin bad++; $display("FAIL csn_oe: got %b want 0", miso_oe); end
    do_read(8'h05, r);
    total++;
    if (r !== 8'hA5) begin bad++; $display("FAIL read_05: got %h want a5", r); end
  endtask

  task automatic test_busy_timing();
    logic [7:0] r;
    frame1(8'h06);
    cs_start();
    xfer(8'h02, 8, r);
    xfer(8'h06, 8, r);
    xfer(8'h5B, 8, r);
    #20;
    csn = 1'b1;
    #((WC - 5) * 10);
    total++;
    if (wip_o !== 1'b1) begin bad++; $display("FAIL busy_hold: got %b want 1", wip_o); end
    #150;
    total++;
    if (wip_o !== 1'b0) begin bad++; $display("FAIL busy_end: got %b want 0", wip_o); end
    #100;
    do_read(8'h06, r);
    total++;
    if (r !== 8'h5B) begin bad++; $display("FAIL read_06: got %h want 5b", r); end
  endtask

  task automatic test_no_wren();
    logic [7:0] r;
    int e0;
    write_mem(8'h10, 8'h5A);
    e0 = err_pulses;
    do_write_raw(8'h10, 8'h3C);
    total++;
    if (err_pulses !== e0 + 1) begin
      bad++; $display("FAIL nowren_err: got %0d want %0d", err_pulses - e0, 1);
    end
    total++;
    if (wip_o !== 1'b0) begin bad++; $display("FAIL nowren_wip: got %b want 0", wip_o); end
    do_read(8'h10, r);
    total++;
    if (r !== 8'h5A) begin bad++; $display("FAIL nowren_mem: got %h want 5a", r); end
  endtask

  task automatic test_protect();
    logic [7:0] r, s;
    int e0;
    write_mem(8'h50, 8'h99);
    frame1(8'h06);
    cs_start(); xfer(8'h01, 8, r); xfer(8'h08, 8, r); cs_end();
    total++;
    if (bp_o !== 2'd2 || wel_o !== 1'b0) begin
      bad++; $display("FAIL wrsr_bp: got bp=%0d wel=%b want bp=2 wel=0", bp_o, wel_o);
    end
    read_status(s);
    total++;
    if (s !== 8'h08) begin bad++; $display("FAIL prot_rdsr: got %h want 08", s); end
    frame1(8'h06);
    e0 = err_pulses;
    do_write_raw(8'h50, 8'h77);
    total++;
    if (err_pulses !== e0 + 1 || wip_o !== 1'b0 || wel_o !== 1'b0) begin
      bad++; $display("FAIL prot_reject: got err=%0d wip=%b wel=%b want 1 0 0",
                      err_pulses - e0, wip_o, wel_o);
    end
    frame1(8'h06);
    do_write_raw(8'h10, 8'h11);
    wait_idle("prot_low");
    do_read(8'h10, r);
    total++;
    if (r !== 8'h11) begin bad++; $display("FAIL prot_low_mem: got %h want 11", r); end
    do_read(8'h50, r);
    total++;
    if (r !== 8'h99) begin bad++; $display("FAIL prot_high_mem: got %h want 99", r); end
    frame1(8'h06);
    cs_start(); xfer(8'h01, 8, r); xfer(8'h00, 8, r); cs_end();
    total++;
    if (bp_o !== 2'd0) begin bad++; $display("FAIL bp_clear: got %0d want 0", bp_o); end
  endtask

  task automatic test_abort();
    logic [7:0] r;
    write_mem(8'h20, 8'h44);
    frame1(8'h06);
    cs_start();
    xfer(8'h02, 8, r);
    xfer(8'h20, 8, r);
    xfer(8'hFF, 5, r);
    cs_end();
    total++;
    if (wip_o !== 1'b0 || wel_o !== 1'b1) begin
      bad++; $display("FAIL abort_status: got wip=%b wel=%b want 0 1", wip_o, wel_o);
    end
    do_read(8'h20, r);
    total++;
    if (r !== 8'h44) begin bad++; $display("FAIL abort_mem: got %h want 44", r); end
    frame1(8'h04);
    total++;
    if (wel_o !== 1'b0) begin bad++; $display("FAIL wrdi_wel: got %b want 0", wel_o); end
  endtask

  task automatic test_seq_read();
    logic [7:0] r, b1, b2;
    logic oe;
    write_mem(8'h7F, 8'h11);
    write_mem(8'h00, 8'h22);
    cs_start();
    xfer(8'h03, 8, r);
    xfer(8'h7F, 8, r);
    xfer(8'h00, 8, b1);
    xfer(8'h00, 8, b2);
    #20;
    oe = miso_oe;
    cs_end();
    total++;
    if (b1 !== 8'h11) begin bad++; $display("FAIL seq_b1: got %h want 11", b1); end
`ifdef SPI_EEPROM_SEQ_READ_EN
    total++;
    if (b2 !== 8'h22 || oe !== 1'b1) begin
      bad++; $display("FAIL seq_b2: got %h oe=%b want 22 oe=1", b2, oe);
    end
`else
    total++;
    if (b2 !== 8'h00 || oe !== 1'b0) begin
      bad++; $display("FAIL seq_b2: got %h oe=%b want 00 oe=0", b2, oe);
    end
`endif
  endtask

  task automatic test_reset_busy();
    logic [7:0] r, s;
    int e0;
    write_mem(8'h30, 8'h66);
    frame1(8'h06);
    do_write_raw(8'h30, 8'hC3);
    total++;
    if (wip_o !== 1'b1) begin bad++; $display("FAIL rb_wip: got %b want 1", wip_o); end
    e0 = err_pulses;
    frame1(8'h06);
    total++;
    if (err_pulses !== e0 + 1) begin
      bad++; $display("FAIL busy_reject: got %0d want 1", err_pulses - e0);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({miso, miso_oe, wip_o, wel_o, bp_o, cmd_err} !== 7'b0) begin
      bad++; $display("FAIL rb_outs: got %b want 0000000",
                      {miso, miso_oe, wip_o, wel_o, bp_o, cmd_err});
    end
    #29;
    rst = 1'b1;
    #50;
    read_status(s);
    total++;
    if (s !== 8'h00) begin bad++; $display("FAIL rb_rdsr: got %h want 00", s); end
    #(WC * 10 + 200);
    do_read(8'h30, r);
    total++;
    if (r !== 8'h66) begin bad++; $display("FAIL rb_mem: got %h want 66", r); end
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #50;
    test_reset();
    test_write_poll_read();
    test_busy_timing();
    test_no_wren();
    test_protect();
    test_abort();
    test_seq_read();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
